// File: rtl/div_unit_controller_pkg.sv
// +----------------------------------------------------------------------+
// | Package : MulDivUnitTypes                                            |
// | Shared types and defaults for the divider lane-arbitration control.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package MulDivUnitTypes;

    localparam int DIV_LATENCY_DEFAULT = 34;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        FINISHED = 2'd2
    } DivCtrlState;

    // Index width that stays legal even for a single-lane build.
    function automatic int lane_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit_controller_rr_lane_picker.sv
// +----------------------------------------------------------------------+
// | Module  : rr_lane_picker                                             |
// | Round-robin pick of one requesting lane, searching from rr_ptr_i.    |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_lane_picker
    import MulDivUnitTypes::*;
#(
    parameter int LANE_NUM = 2,
    localparam int c_LANE_W = lane_idx_width(LANE_NUM)
) (
    input  logic [LANE_NUM-1:0] req_i,
    input  logic [c_LANE_W-1:0] rr_ptr_i,
    output logic [LANE_NUM-1:0] grant_o,
    output logic [c_LANE_W-1:0] idx_o,
    output logic                valid_o
);

    int w_lane;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_lane  = 0;
        for (int i = 0; i < LANE_NUM; i++) begin
            w_lane = int'(rr_ptr_i) + i;
            if (w_lane >= LANE_NUM) begin
                w_lane = w_lane - LANE_NUM;
            end
            for (int j = 0; j < LANE_NUM; j++) begin
                if (!valid_o && (w_lane == j) && req_i[j]) begin
                    valid_o    = 1'b1;
                    grant_o[j] = 1'b1;
                    idx_o      = c_LANE_W'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_unit_controller.sv
// +----------------------------------------------------------------------+
// | Module  : div_unit_controller                                        |
// | Arbitrates one shared divider among lanes and tracks its ownership.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module div_unit_controller
    import MulDivUnitTypes::*;
#(
    parameter int LANE_NUM     = 2,
    parameter int DIV_LATENCY  = DIV_LATENCY_DEFAULT,
    parameter int AL_PTR_WIDTH = 6,
    localparam int c_LANE_W    = lane_idx_width(LANE_NUM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic [LANE_NUM-1:0]              divReq,
    input  logic [LANE_NUM*AL_PTR_WIDTH-1:0] divReqPtr,
    input  logic                             ownerFlush,
    input  logic [LANE_NUM-1:0]              divRelease,
    output logic [LANE_NUM-1:0]              divGrant,
    output logic                             divStart,
    output logic [LANE_NUM-1:0]              divFinished,
    output logic                             divBusy,
    output logic [AL_PTR_WIDTH-1:0]          ownerPtr,
    output logic [c_LANE_W-1:0]              ownerLane
);

    localparam int c_CNT_W = 8;
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(LANE_NUM - 1);

    DivCtrlState             state_q;
    logic [c_CNT_W-1:0]      cnt_q;
    logic [c_LANE_W-1:0]     rr_ptr_q;
    logic [c_LANE_W-1:0]     owner_lane_q;
    logic [AL_PTR_WIDTH-1:0] owner_ptr_q;

    logic [LANE_NUM-1:0]     w_pick_grant;
    logic [c_LANE_W-1:0]     w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_grant_en;
    logic [AL_PTR_WIDTH-1:0] w_req_ptr;
    logic [LANE_NUM-1:0]     w_owner_onehot;
    logic                    w_owner_release;

    rr_lane_picker #(
        .LANE_NUM (LANE_NUM)
    ) u_picker (
        .req_i    (divReq),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (w_pick_grant),
        .idx_o    (w_pick_idx),
        .valid_o  (w_pick_valid)
    );

    assign w_grant_en = !rst && !stall && (state_q == IDLE) && w_pick_valid;

    always_comb begin
        w_req_ptr      = '0;
        w_owner_onehot = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            if (w_pick_idx == c_LANE_W'(i)) begin
                w_req_ptr = divReqPtr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH];
            end
            if (owner_lane_q == c_LANE_W'(i)) begin
                w_owner_onehot[i] = 1'b1;
            end
        end
    end

    assign w_owner_release = |(divRelease & w_owner_onehot);

    // Counter is loaded with LATENCY-1 and BUSY ends as it reaches zero,
    // so the result is valid exactly DIV_LATENCY cycles after divStart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            owner_lane_q <= '0;
            owner_ptr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_grant_en) begin
                        state_q      <= BUSY;
                        cnt_q        <= c_CNT_W'(DIV_LATENCY - 1);
                        owner_lane_q <= w_pick_idx;
                        owner_ptr_q  <= w_req_ptr;
                        rr_ptr_q     <= (w_pick_idx == c_LAST_LANE) ? '0
                                        : w_pick_idx + c_LANE_W'(1);
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - c_CNT_W'(1);
                    if (ownerFlush) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_W'(1)) begin
                        state_q <= FINISHED;
                    end
                end
                FINISHED: begin
                    if (ownerFlush || (w_owner_release && !stall)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign divGrant    = w_grant_en ? w_pick_grant : '0;
    assign divStart    = w_grant_en;
    assign divFinished = (!rst && (state_q == FINISHED)) ? w_owner_onehot : '0;
    assign divBusy     = !rst && (state_q != IDLE);
    assign ownerPtr    = owner_ptr_q;
    assign ownerLane   = owner_lane_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit_controller.sv
// +----------------------------------------------------------------------+
// | Module  : tb_div_unit_controller                                     |
// | Scoreboard bench for div_unit_controller, DIV_LATENCY = 4.           |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_div_unit_controller;

    localparam int        LAT = 4;
    localparam logic [5:0] P0 = 6'h15;
    localparam logic [5:0] P1 = 6'h2A;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  divReq;
    logic [11:0] divReqPtr;
    logic        ownerFlush;
    logic [1:0]  divRelease;
    logic [1:0]  divGrant;
    logic        divStart;
    logic [1:0]  divFinished;
    logic        divBusy;
    logic [5:0]  ownerPtr;
    logic        ownerLane;

    div_unit_controller #(
        .LANE_NUM     (2),
        .DIV_LATENCY  (LAT),
        .AL_PTR_WIDTH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .divReq      (divReq),
        .divReqPtr   (divReqPtr),
        .ownerFlush  (ownerFlush),
        .divRelease  (divRelease),
        .divGrant    (divGrant),
        .divStart    (divStart),
        .divFinished (divFinished),
        .divBusy     (divBusy),
        .ownerPtr    (ownerPtr),
        .ownerLane   (ownerLane)
    );

    typedef struct {
        logic [1:0] vec;
        logic [5:0] ptr;
        int         lane;
        int         cyc;
    } exp_t;

    exp_t exp_grant_q[$];
    exp_t exp_fin_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [1:0] prev_fin = 2'b00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT starts or finishes a job.
    always @(negedge clk) begin
        exp_t e;
        if (divStart) begin
            if (exp_grant_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                e = exp_grant_q.pop_front();
                chk("grant_vec", int'(divGrant), int'(e.vec));
                chk("grant_cycle", cyc, e.cyc);
            end
        end else if (divGrant != 2'b00) begin
            chk("grant_without_start", int'(divGrant), 0);
        end
        if (divFinished != 2'b00 && prev_fin == 2'b00) begin
            if (exp_fin_q.size() == 0) begin
                chk("unexpected_finish", int'(divFinished), 0);
            end else begin
                e = exp_fin_q.pop_front();
                chk("finish_vec", int'(divFinished), int'(e.vec));
                chk("finish_ptr", int'(ownerPtr), int'(e.ptr));
                chk("finish_lane", int'(ownerLane), e.lane);
                chk("finish_cycle", cyc, e.cyc);
            end
        end
        prev_fin <= divFinished;
    end

    task automatic cycle(input logic [1:0] req, input logic [1:0] rel,
                         input logic flush, input logic stl, input logic r);
        @(posedge clk);
        #1;
        divReq     = req;
        divRelease = rel;
        ownerFlush = flush;
        stall      = stl;
        rst        = r;
    endtask

    task automatic issue(input logic [1:0] req, input logic [1:0] exp_vec, input bit fin);
        exp_t e;
        cycle(req, 2'b00, 1'b0, 1'b0, 1'b0);
        e.vec  = exp_vec;
        e.lane = (exp_vec == 2'b10) ? 1 : 0;
        e.ptr  = (exp_vec == 2'b10) ? P1 : P0;
        e.cyc  = cyc;
        exp_grant_q.push_back(e);
        if (fin) begin
            e.cyc = cyc + LAT;
            exp_fin_q.push_back(e);
        end
        #3 chk("busy_at_grant", int'(divBusy), 0);
    endtask

    task automatic wait_finish();
        for (int i = 1; i <= LAT; i++) begin
            cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            #3 chk("busy_while_running", int'(divBusy), 1);
            if (i < LAT) chk("no_early_finish", int'(divFinished), 0);
        end
    endtask

    task automatic release_owner(input logic [1:0] rel);
        cycle(2'b00, rel, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #3 chk("idle_after_release", int'(divBusy), 0);
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        divReq     = 2'b00;
        divRelease = 2'b00;
        ownerFlush = 1'b0;
        divReqPtr  = {P1, P0};

        // Reset with requests pending: nothing may be granted.
        cycle(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
        #3;
        chk("rst_grant", int'(divGrant), 0);
        chk("rst_start", int'(divStart), 0);
        chk("rst_busy", int'(divBusy), 0);
        chk("rst_finished", int'(divFinished), 0);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        #3;
        chk("rst_owner_ptr", int'(ownerPtr), 0);
        chk("rst_owner_lane", int'(ownerLane), 0);

        // Stall in IDLE blocks the grant.
        cycle(2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
        #3;
        chk("stall_grant", int'(divGrant), 0);
        chk("stall_start", int'(divStart), 0);

        // Both lanes request: lane0 first, then lane1.
        issue(2'b11, 2'b01, 1'b1);
        wait_finish();
        release_owner(2'b01);
        issue(2'b11, 2'b10, 1'b1);
        wait_finish();
        release_owner(2'b10);

        // Single job, non-owner release, stalled release, then release.
        issue(2'b01, 2'b01, 1'b1);
        wait_finish();
        cycle(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        #3 chk("nonowner_release_ignored", int'(divFinished), 1);
        cycle(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        #3 chk("stalled_release_holds", int'(divFinished), 1);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #3;
        chk("release_to_idle_busy", int'(divBusy), 0);
        chk("release_to_idle_fin", int'(divFinished), 0);

        // Flush during BUSY: no finish, new grant afterwards.
        issue(2'b10, 2'b10, 1'b0);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #3 chk("flush_pre_busy", int'(divBusy), 1);
        cycle(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        #3 chk("flush_cycle_busy", int'(divBusy), 1);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #3;
        chk("flush_idle_busy", int'(divBusy), 0);
        chk("flush_idle_fin", int'(divFinished), 0);
        issue(2'b11, 2'b01, 1'b1);
        wait_finish();

        // Flush together with release in FINISHED.
        cycle(2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #3;
        chk("flush_rel_busy", int'(divBusy), 0);
        chk("flush_rel_fin", int'(divFinished), 0);

        // Pointer sits at lane1; a lane0-only request wraps around.
        issue(2'b01, 2'b01, 1'b1);
        wait_finish();
        release_owner(2'b01);
        issue(2'b11, 2'b10, 1'b1);
        wait_finish();
        release_owner(2'b10);

        // Reset while BUSY aborts the job and rewinds the pointer.
        issue(2'b11, 2'b01, 1'b0);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst_busy_grant", int'(divGrant), 0);
        chk("rst_busy_start", int'(divStart), 0);
        chk("rst_busy_busy", int'(divBusy), 0);
        chk("rst_busy_fin", int'(divFinished), 0);
        chk("rst_busy_ptr", int'(ownerPtr), 0);
        chk("rst_busy_lane", int'(ownerLane), 0);
        issue(2'b11, 2'b01, 1'b1);
        wait_finish();
        release_owner(2'b01);

        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("grant_queue_drained", exp_grant_q.size(), 0);
        chk("finish_queue_drained", exp_fin_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/div_unit_controller.md
DIV_UNIT_CONTROLLER -- requirements
Module: div_unit_controller

Interface
REQ-001 The block SHALL have parameter LANE_NUM, default 2: number of memory lanes sharing one divider.
REQ-002 The block SHALL have parameter DIV_LATENCY, default 34: cycles from start to result valid; legal range 2..255.
REQ-003 The block SHALL have parameter AL_PTR_WIDTH, default 6: active-list pointer width.
REQ-004 The block SHALL have port clk, input, 1: clock.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port stall, input, 1: backend stall.
REQ-007 The block SHALL have port divReq, input, LANE_NUM: per-lane divide request.
REQ-008 The block SHALL have port divReqPtr, input, LANE_NUM x AL_PTR_WIDTH: active-list pointer of each requester.
REQ-009 The block SHALL have port ownerFlush, input, 1: selective-flush hit on ownerPtr, computed outside.
REQ-010 The block SHALL have port divRelease, input, LANE_NUM: owner consumed result in memory access stage.
REQ-011 The block SHALL have port divGrant, output, LANE_NUM: one-hot grant.
REQ-012 The block SHALL have port divStart, output, 1: single-cycle start pulse to divider datapath.
REQ-013 The block SHALL have port divFinished, output, LANE_NUM: result valid, owner lane only.
REQ-014 The block SHALL have port divBusy, output, 1: divider not idle; gates divide issue from IQ.
REQ-015 The block SHALL have port ownerPtr, output, AL_PTR_WIDTH: registered pointer of current owner.
REQ-016 The block SHALL have port ownerLane, output, clog2(LANE_NUM): registered index of current owner.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and FINISHED.
REQ-018 In IDLE with any divReq and !stall, divGrant SHALL be asserted combinationally for one lane, chosen round-robin starting at rrPtr.
REQ-019 On grant, divStart SHALL equal 1 in the same cycle; ownerLane/ownerPtr SHALL be registered; counter SHALL load DIV_LATENCY-1; state SHALL go to BUSY; rrPtr SHALL become (granted lane + 1) mod LANE_NUM.
REQ-020 With stall=1 in IDLE, divGrant and divStart SHALL be 0 and no state SHALL change.
REQ-021 In BUSY, the counter SHALL decrement every cycle regardless of stall; at counter==0 the next state SHALL be FINISHED.
REQ-022 In FINISHED, divFinished[ownerLane] SHALL equal 1, with all other bits 0.
REQ-023 In FINISHED, divRelease[ownerLane] && !stall SHALL move the FSM to IDLE; release on a non-owner lane SHALL be ignored.
REQ-024 ownerFlush in BUSY or FINISHED SHALL force IDLE next cycle, with priority over release and counter expiry; ownerFlush SHALL be ignored in IDLE.
REQ-025 divBusy SHALL equal (state != IDLE); no grant SHALL occur in the cycle the FSM leaves BUSY/FINISHED, so there is a one-cycle minimum gap between jobs.
REQ-026 divGrant SHALL equal 0 in BUSY and FINISHED.
REQ-027 Lane indices SHALL wrap modulo LANE_NUM.

Reset
REQ-028 While rst=1, the block SHALL set state=IDLE, counter=0, rrPtr=0, ownerLane=0 and ownerPtr=0; all outputs SHALL equal 0; reset SHALL abort any in-flight job without divFinished.

Structure
REQ-029 The state enum DivCtrlState SHALL be defined in a shared package MulDivUnitTypes, with the DIV_LATENCY default held there as a localparam.
REQ-030 The round-robin pick SHALL be a sub-module rr_lane_picker (req vector + rrPtr -> one-hot grant and index).

Verification
REQ-031 With DIV_LATENCY=4, divReq=01 at cycle 0: grant=01 and divStart at cycle 0, divBusy cycles 1-4, divFinished=01 at cycle 4.
REQ-032 With divReq=11 and rrPtr=0, the bench SHALL see grant lane0 first; after release, the next grant SHALL go to lane1.
REQ-033 With ownerFlush at BUSY cycle 2: IDLE at cycle 3, divFinished never asserted, new grant possible at cycle 4.
REQ-034 In FINISHED with divRelease=10 from the non-owner lane: state SHALL stay FINISHED; with divRelease=01 and stall=1, the FSM SHALL hold; with stall=0, IDLE SHALL follow next cycle.
REQ-035 With rst in BUSY: the next cycle SHALL show all outputs 0 and rrPtr=0.
REQ-036 With simultaneous ownerFlush and divRelease in FINISHED: IDLE SHALL follow next cycle, and divFinished SHALL drop.
